pt_ram_reader: RTL and testbench

- Drains sorted points out of the point RAM read port (port B) after the bitonic sorter completes a pass. Presents them as a valid/ready output stream to downstream consumers.
- Sits beside bitonic_sort on the same ram_simple_dual instance. It owns addrb only while busy; the sorter owns it otherwise.
- Hides the RAM's 1-cycle registered read latency with a 2-entry output buffer, so throughput is one word per clock under continuous ready.

---
 rtl/pt_ram_reader.sv | 180 ++++++++++++++++++
 tb/tb_pt_ram_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pt_ram_reader.sv
// pt_ram_reader: streams a range of point RAM words out over valid/ready.
// Reads are issued on RAM port B in ascending or descending address order.
// A 2-entry output buffer hides the RAM's registered read latency.
// The most recent read may also stay parked on pt_ram_dob: addrb is held
// while that word waits, so the RAM keeps returning the same word.
module pt_ram_reader #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_BITS:0]    count,
    input  logic                  descending,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_BITS-1:0]  pt_ram_addrb,
    input  logic [DATA_WIDTH-1:0] pt_ram_dob,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int unsigned CNT_W = ADDR_BITS + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state, state_nx;

    // Readout parameters and progress
    logic [CNT_W-1:0] count_q;
    logic             desc_q;
    logic [CNT_W-1:0] cnt;

    // Read pipeline tracking: address presented, then word on dob
    logic rd_pend, rd_last;
    logic dob_v, dob_last;

    // Second buffer entry behind the m_* output register
    logic                  skid_v;
    logic                  skid_last;
    logic [DATA_WIDTH-1:0] skid_data;

    // Combinational control
    logic             pop, cap, room, issue, issue_last, done_nx, dob_v_nx;
    logic [1:0]       occ, occ_post;
    logic [CNT_W-1:0] issue_count, issue_cnt, issue_addr;
    logic             issue_desc;

    // Next-state, issue decision and buffer flow control
    always_comb begin
        state_nx    = state;
        issue       = 1'b0;
        done_nx     = 1'b0;
        issue_count = count_q;
        issue_desc  = desc_q;
        issue_cnt   = cnt;

        pop      = m_valid & m_ready;
        occ      = 2'(m_valid) + 2'(skid_v) - 2'(pop);
        cap      = dob_v & (occ != 2'd2);
        occ_post = occ + 2'(cap);
        dob_v_nx = rd_pend | (dob_v & ~cap);
        // A new address may only displace the word on dob if that word is sure to be captured
        room     = ~dob_v_nx | (occ_post != 2'd2);

        unique case (state)
            S_IDLE: begin
                // done high means the previous readout is still finishing
                if (start && !done) begin
                    if (count == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        issue       = 1'b1;
                        issue_count = count;
                        issue_desc  = descending;
                        issue_cnt   = '0;
                        state_nx    = (count == CNT_W'(1)) ? S_DRAIN : S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (room) begin
                    issue = 1'b1;
                    if (cnt + CNT_W'(1) == count_q) begin
                        state_nx = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && m_last) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        issue_last = (issue_cnt + CNT_W'(1)) == issue_count;
        issue_addr = issue_desc ? CNT_W'(issue_count - issue_cnt - CNT_W'(1)) : issue_cnt;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Address issue, read pipeline, output buffer and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            pt_ram_addrb <= '0;
            count_q      <= '0;
            desc_q       <= 1'b0;
            cnt          <= '0;
            rd_pend      <= 1'b0;
            rd_last      <= 1'b0;
            dob_v        <= 1'b0;
            dob_last     <= 1'b0;
            skid_v       <= 1'b0;
            skid_last    <= 1'b0;
            skid_data    <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            m_last       <= 1'b0;
        end else begin
            busy <= (state_nx != S_IDLE);
            done <= done_nx;

            if (issue) begin
                pt_ram_addrb <= ADDR_BITS'(issue_addr);
                cnt          <= issue_cnt + CNT_W'(1);
                count_q      <= issue_count;
                desc_q       <= issue_desc;
                rd_last      <= issue_last;
            end
            rd_pend <= issue;

            dob_v <= dob_v_nx;
            if (rd_pend) begin
                dob_last <= rd_last;
            end

            if (pop || !m_valid) begin
                if (skid_v) begin
                    m_valid <= 1'b1;
                    m_data  <= skid_data;
                    m_last  <= skid_last;
                    skid_v  <= cap;
                    if (cap) begin
                        skid_data <= pt_ram_dob;
                        skid_last <= dob_last;
                    end
                end else if (cap) begin
                    m_valid <= 1'b1;
                    m_data  <= pt_ram_dob;
                    m_last  <= dob_last;
                end else begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            end else if (cap) begin
                skid_v    <= 1'b1;
                skid_data <= pt_ram_dob;
                skid_last <= dob_last;
            end
        end
    end

endmodule

// File: tb/tb_pt_ram_reader.sv
// Testbench for pt_ram_reader: behavioural RAM plus a queue-based expected-stream model.
module tb_pt_ram_reader;

    localparam int unsigned AB = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned N  = 1 << AB;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AB:0]   count;
    logic          descending;
    logic          busy;
    logic          done;
    logic [AB-1:0] pt_ram_addrb;
    logic [DW-1:0] pt_ram_dob;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    logic [DW-1:0] mem [N];

    int total = 0;
    int bad   = 0;

    // Observations collected by run_xfer
    logic [DW-1:0] got_data [$];
    bit            got_last [$];
    int            got_k    [$];
    logic [DW-1:0] exp_data [$];
    int done_cnt, done_k, busy_cnt, busy_at_done, stab_err, max_addr, timed_out;

    pt_ram_reader #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .count        (count),
        .descending   (descending),
        .busy         (busy),
        .done         (done),
        .pt_ram_addrb (pt_ram_addrb),
        .pt_ram_dob   (pt_ram_dob),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last)
    );

    always #5 clk = ~clk;

    // Registered-read RAM model
    always @(posedge clk) pt_ram_dob <= mem[pt_ram_addrb];

    task automatic fill_linear();
        for (int i = 0; i < int'(N); i++) mem[i] = DW'(i * 3);
    endtask

    // Expected stream: n words, address order by direction
    task automatic build_expected(input int n, input bit desc);
        exp_data.delete();
        for (int i = 0; i < n; i++) exp_data.push_back(mem[desc ? (n - 1 - i) : i]);
    endtask

    // One readout: mode 0 ready=1, 1 fixed toggle pattern, 2 random; pulse_k injects a stray start
    task automatic run_xfer(input int n, input bit desc, input int mode, input int pulse_k, input int budget);
        bit            pat [6];
        bit            stalled;
        bit            rdy;
        bit            pl;
        logic [DW-1:0] pd;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        stalled = 1'b0; pd = '0; pl = 1'b0;
        got_data.delete(); got_last.delete(); got_k.delete();
        done_cnt = 0; done_k = -1; busy_cnt = 0; busy_at_done = -1;
        stab_err = 0; max_addr = -1; timed_out = 0;
        @(negedge clk);
        start = 1'b1; count = (AB + 1)'(n); descending = desc; m_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < budget; k++) begin
            if (k > 0) @(negedge clk);
            start = (k == pulse_k);
            if (start) count = (AB + 1)'(5);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[k % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            m_ready = rdy;
            if (stalled && (!m_valid || m_data !== pd || m_last !== pl)) stab_err++;
            if (m_valid && rdy) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_k.push_back(k);
            end
            stalled = m_valid && !rdy;
            pd = m_data; pl = m_last;
            if (busy) begin
                busy_cnt++;
                if (int'(pt_ram_addrb) > max_addr) max_addr = int'(pt_ram_addrb);
            end
            if (done) begin
                done_cnt++;
                if (done_k < 0) begin
                    done_k = k;
                    busy_at_done = int'(busy);
                end
            end
            if (done_k >= 0 && k >= done_k + 4) break;
        end
        if (done_k < 0) timed_out = 1;
        start = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; count = '0; descending = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", m_last); end
        total++; if (m_data !== '0) begin bad++; $display("FAIL reset_data got=%0h exp=0", m_data); end
        total++; if (pt_ram_addrb !== '0) begin bad++; $display("FAIL reset_addrb got=%0d exp=0", pt_ram_addrb); end
        rst = 1'b0;
    endtask

    task automatic test_ascending();
        fill_linear();
        build_expected(8, 1'b0);
        run_xfer(8, 1'b0, 0, -1, 100);
        total++; if (timed_out != 0) begin bad++; $display("FAIL asc_timeout got=%0d exp=0", timed_out); end
        total++; if (got_data.size() != 8) begin bad++; $display("FAIL asc_beats got=%0d exp=8", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 8; i++) begin
            total++; if (got_data[i] !== exp_data[i]) begin bad++; $display("FAIL asc_data[%0d] got=%0d exp=%0d", i, got_data[i], exp_data[i]); end
            total++; if (got_last[i] !== (i == 7)) begin bad++; $display("FAIL asc_last[%0d] got=%b exp=%b", i, got_last[i], i == 7); end
            total++; if (got_k[i] != 2 + i) begin bad++; $display("FAIL asc_timing[%0d] got=%0d exp=%0d", i, got_k[i], 2 + i); end
        end
        total++; if (done_k != 10) begin bad++; $display("FAIL asc_done_cycle got=%0d exp=10", done_k); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL asc_done_count got=%0d exp=1", done_cnt); end
        total++; if (busy_cnt != 10) begin bad++; $display("FAIL asc_busy_cycles got=%0d exp=10", busy_cnt); end
        total++; if (busy_at_done != 0) begin bad++; $display("FAIL asc_busy_at_done got=%0d exp=0", busy_at_done); end
    endtask

    task automatic test_descending();
        fill_linear();
        build_expected(5, 1'b1);
        run_xfer(5, 1'b1, 0, -1, 100);
        total++; if (got_data.size() != 5) begin bad++; $display("FAIL desc_beats got=%0d exp=5", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 5; i++) begin
            total++; if (got_data[i] !== exp_data[i]) begin bad++; $display("FAIL desc_data[%0d] got=%0d exp=%0d", i, got_data[i], exp_data[i]); end
            total++; if (got_last[i] !== (i == 4)) begin bad++; $display("FAIL desc_last[%0d] got=%b exp=%b", i, got_last[i], i == 4); end
        end
        total++; if (max_addr != 4) begin bad++; $display("FAIL desc_max_addr got=%0d exp=4", max_addr); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL desc_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_backpressure();
        fill_linear();
        build_expected(8, 1'b0);
        run_xfer(8, 1'b0, 1, -1, 300);
        total++; if (timed_out != 0) begin bad++; $display("FAIL bp_timeout got=%0d exp=0", timed_out); end
        total++; if (got_data.size() != 8) begin bad++; $display("FAIL bp_beats got=%0d exp=8", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 8; i++) begin
            total++; if (got_data[i] !== exp_data[i]) begin bad++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, got_data[i], exp_data[i]); end
            total++; if (got_last[i] !== (i == 7)) begin bad++; $display("FAIL bp_last[%0d] got=%b exp=%b", i, got_last[i], i == 7); end
        end
        total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stab_err); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_count_zero_and_stray_start();
        fill_linear();
        run_xfer(0, 1'b0, 0, -1, 20);
        total++; if (done_k != 0) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=0", done_k); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
        total++; if (got_data.size() != 0) begin bad++; $display("FAIL zero_beats got=%0d exp=0", got_data.size()); end
        total++; if (busy_cnt != 0) begin bad++; $display("FAIL zero_busy got=%0d exp=0", busy_cnt); end
        // Stray start while busy
        build_expected(8, 1'b0);
        run_xfer(8, 1'b0, 0, 3, 100);
        total++; if (got_data.size() != 8) begin bad++; $display("FAIL stray_beats got=%0d exp=8", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 8; i++) begin
            total++; if (got_data[i] !== exp_data[i]) begin bad++; $display("FAIL stray_data[%0d] got=%0d exp=%0d", i, got_data[i], exp_data[i]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL stray_done_count got=%0d exp=1", done_cnt); end
        // Start presented in the cycle done is high: done lands at k=8 for 6 beats
        run_xfer(6, 1'b1, 0, 8, 100);
        total++; if (done_k != 8) begin bad++; $display("FAIL done_start_cycle got=%0d exp=8", done_k); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL done_start_count got=%0d exp=1", done_cnt); end
        total++; if (busy_cnt != 8) begin bad++; $display("FAIL done_start_busy got=%0d exp=8", busy_cnt); end
    endtask

    task automatic test_full_ram();
        int errs;
        int lerrs;
        int terrs;
        fill_linear();
        build_expected(int'(N), 1'b0);
        run_xfer(int'(N), 1'b0, 0, -1, int'(N) + 50);
        total++; if (got_data.size() != int'(N)) begin bad++; $display("FAIL full_beats got=%0d exp=%0d", got_data.size(), N); end
        errs = 0; lerrs = 0; terrs = 0;
        for (int i = 0; i < got_data.size() && i < int'(N); i++) begin
            if (got_data[i] !== exp_data[i]) errs++;
            if (got_last[i] !== (i == int'(N) - 1)) lerrs++;
            if (got_k[i] != 2 + i) terrs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL full_data got=%0d_errors exp=0", errs); end
        total++; if (lerrs != 0) begin bad++; $display("FAIL full_last got=%0d_errors exp=0", lerrs); end
        total++; if (terrs != 0) begin bad++; $display("FAIL full_timing got=%0d_errors exp=0", terrs); end
        total++; if (max_addr != int'(N) - 1) begin bad++; $display("FAIL full_max_addr got=%0d exp=%0d", max_addr, N - 1); end
        total++; if (done_k != int'(N) + 2) begin bad++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_k, N + 2); end
    endtask

    task automatic test_reset_mid();
        int nhs;
        int cyc;
        fill_linear();
        @(negedge clk);
        start = 1'b1; count = (AB + 1)'(8); descending = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; nhs = 0; cyc = 0;
        while (nhs < 3 && cyc < 50) begin
            if (m_valid && m_ready) nhs++;
            cyc++;
            @(negedge clk);
        end
        total++; if (nhs != 3) begin bad++; $display("FAIL rstmid_beats got=%0d exp=3", nhs); end
        rst = 1'b1; m_ready = 1'b0;
        @(negedge clk);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", m_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (done !== 1'b0 || m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_quiet[%0d] got=%b%b exp=00", i, done, m_valid); end
        end
        build_expected(4, 1'b0);
        run_xfer(4, 1'b0, 0, -1, 50);
        total++; if (got_data.size() != 4) begin bad++; $display("FAIL rstmid_new_beats got=%0d exp=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            total++; if (got_data[i] !== exp_data[i]) begin bad++; $display("FAIL rstmid_new_data[%0d] got=%0d exp=%0d", i, got_data[i], exp_data[i]); end
        end
        total++; if (got_k.size() > 0 && got_k[0] != 2) begin bad++; $display("FAIL rstmid_new_latency got=%0d exp=2", got_k[0]); end
    endtask

    task automatic test_random();
        int n;
        bit d;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            n = $urandom_range(1, 24);
            d = 1'($urandom_range(0, 1));
            build_expected(n, d);
            run_xfer(n, d, 2, -1, 400);
            total++; if (got_data.size() != n) begin bad++; $display("FAIL rnd%0d_beats got=%0d exp=%0d", it, got_data.size(), n); end
            for (int i = 0; i < got_data.size() && i < n; i++) begin
                total++; if (got_data[i] !== exp_data[i]) begin bad++; $display("FAIL rnd%0d_data[%0d] got=%0h exp=%0h", it, i, got_data[i], exp_data[i]); end
                total++; if (got_last[i] !== (i == n - 1)) begin bad++; $display("FAIL rnd%0d_last[%0d] got=%b exp=%b", it, i, got_last[i], i == n - 1); end
            end
            total++; if (stab_err != 0) begin bad++; $display("FAIL rnd%0d_stable got=%0d exp=0", it, stab_err); end
            total++; if (done_cnt != 1) begin bad++; $display("FAIL rnd%0d_done_count got=%0d exp=1", it, done_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_backpressure();
        test_count_zero_and_stray_start();
        test_full_ram();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
